// File: rtl/intra_edge_pkg.sv
// -----------------------------------------------------------------------------
// intra_edge_pkg
// Shared definitions for the AV1 intra edge filter:
//   - state_t          : filter FSM encoding (exposed on state_dbg)
//   - KERNEL           : 5-tap smoothing kernels indexed by strength
//   - BLKWH_* / D_*    : block-size and angle-delta thresholds used by the
//                        strength selection ladder
// -----------------------------------------------------------------------------
package intra_edge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_FILTER = 2'd2
   } state_t;

   localparam int KERNEL_TAPS = 5;
   localparam int KERNEL_W    = 5;

   // Row 0 is an identity kernel so strength 0 falls out of the same datapath
   // as the real kernels: (16*e + 8) >> 4 == e.
   localparam logic [KERNEL_W-1:0] KERNEL [0:3][0:KERNEL_TAPS-1] = '{
      '{5'd0, 5'd0, 5'd16, 5'd0, 5'd0},
      '{5'd0, 5'd4, 5'd8,  5'd4, 5'd0},
      '{5'd0, 5'd5, 5'd6,  5'd5, 5'd0},
      '{5'd2, 5'd4, 5'd4,  5'd4, 5'd2}
   };

   // blkWh (= w + h) breakpoints
   localparam int unsigned BLKWH_8  = 8;
   localparam int unsigned BLKWH_12 = 12;
   localparam int unsigned BLKWH_16 = 16;
   localparam int unsigned BLKWH_24 = 24;
   localparam int unsigned BLKWH_32 = 32;

   // |delta| breakpoints
   localparam int unsigned D_1  = 1;
   localparam int unsigned D_4  = 4;
   localparam int unsigned D_8  = 8;
   localparam int unsigned D_16 = 16;
   localparam int unsigned D_20 = 20;
   localparam int unsigned D_32 = 32;
   localparam int unsigned D_40 = 40;
   localparam int unsigned D_48 = 48;
   localparam int unsigned D_56 = 56;
   localparam int unsigned D_64 = 64;

endpackage

// File: rtl/intra_edge_strength_lut.sv
// -----------------------------------------------------------------------------
// intra_edge_strength_lut
// Combinational AV1 intra edge filter strength selection.
// Ports:
//   w, h        : block width / height
//   filter_type : smooth-neighbour filter type (single bit)
//   delta       : signed (two's complement) angle delta
//   strength    : selected strength 0..3
// -----------------------------------------------------------------------------
module intra_edge_strength_lut
   import intra_edge_pkg::*;
#(
   parameter int DIM_W = 10
) (
   input  logic [DIM_W-1:0] w,
   input  logic [DIM_W-1:0] h,
   input  logic             filter_type,
   input  logic [DIM_W-1:0] delta,
   output logic [1:0]       strength
);

   logic [DIM_W:0] abs_d;
   logic [DIM_W:0] blk_wh;
   logic [31:0]    d;
   logic [31:0]    bw;

   always_comb begin
      // One extra bit so |most negative delta| is representable.
      abs_d  = delta[DIM_W-1] ? ({1'b0, ~delta} + (DIM_W+1)'(1)) : {1'b0, delta};
      blk_wh = {1'b0, w} + {1'b0, h};
      d      = 32'(abs_d);
      bw     = 32'(blk_wh);

      strength = 2'd0;
      if (!filter_type) begin
         if (bw <= BLKWH_8) begin
            if (d >= D_56) strength = 2'd1;
         end else if (bw <= BLKWH_12) begin
            if (d >= D_40) strength = 2'd1;
         end else if (bw <= BLKWH_16) begin
            if (d >= D_40) strength = 2'd1;
         end else if (bw <= BLKWH_24) begin
            if (d >= D_8)  strength = 2'd1;
            if (d >= D_16) strength = 2'd2;
            if (d >= D_32) strength = 2'd3;
         end else if (bw <= BLKWH_32) begin
            if (d >= D_1)  strength = 2'd1;
            if (d >= D_4)  strength = 2'd2;
            if (d >= D_32) strength = 2'd3;
         end else begin
            if (d >= D_1)  strength = 2'd3;
         end
      end else begin
         if (bw <= BLKWH_8) begin
            if (d >= D_40) strength = 2'd1;
            if (d >= D_64) strength = 2'd2;
         end else if (bw <= BLKWH_16) begin
            if (d >= D_20) strength = 2'd1;
            if (d >= D_48) strength = 2'd2;
         end else if (bw <= BLKWH_24) begin
            if (d >= D_4)  strength = 2'd3;
         end else begin
            if (d >= D_1)  strength = 2'd3;
         end
      end
   end

endmodule

// File: rtl/intra_edge_filter.sv
// -----------------------------------------------------------------------------
// intra_edge_filter
// Buffers one AV1 intra prediction edge, selects the filter strength and
// streams out the 5-tap smoothed edge.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high; a producer holds valid and its payload until that edge, and
// out_data / out_last hold while out_valid && !out_ready.
//
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   cfg_valid / cfg_ready    : config handshake (w, h, filter_type, delta, sz)
//   in_valid / in_ready      : edge sample input, in_data
//   out_valid / out_ready    : filtered sample output, out_data, out_last
//   strength                 : selected strength, held until next cfg accept
//   state_dbg                : current FSM state
// Optional (INTRA_EDGE_STRENGTH_OVERRIDE_EN defined):
//   strength_ovr_en, strength_ovr : replace the computed strength
// -----------------------------------------------------------------------------
module intra_edge_filter
   import intra_edge_pkg::*;
#(
   parameter int  SAMPLE_W = 10,
   parameter int  MAX_EDGE = 64,
   parameter int  DIM_W    = 10,
   localparam int SZ_W     = $clog2(MAX_EDGE + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [DIM_W-1:0]    w,
   input  logic [DIM_W-1:0]    h,
   input  logic [DIM_W-1:0]    filter_type,
   input  logic [DIM_W-1:0]    delta,
   input  logic [SZ_W-1:0]     sz,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [SAMPLE_W-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [SAMPLE_W-1:0] out_data,
   output logic                out_last,
   output logic [1:0]          strength,
   output logic [1:0]          state_dbg
`ifdef INTRA_EDGE_STRENGTH_OVERRIDE_EN
   ,
   input  logic                strength_ovr_en,
   input  logic [1:0]          strength_ovr
`endif
);

   localparam int IDX_W = (MAX_EDGE > 1) ? $clog2(MAX_EDGE) : 1;
   localparam int ACC_W = SAMPLE_W + 4;

   state_t              state, state_n;
   logic [SZ_W-1:0]     idx;
   logic [SZ_W-1:0]     len;
   logic [SZ_W-1:0]     sz_eff;
   logic                idx_last;
   logic [DIM_W-1:0]    w_q, h_q, delta_q;
   logic                ft_q;
   logic [1:0]          lut_strength;
   logic [1:0]          sel_strength;
   logic [SAMPLE_W-1:0] edge_buf [MAX_EDGE];
   logic [ACC_W-1:0]    acc;
   logic [SAMPLE_W-1:0] filt;
   int                  pos;
   logic                unused_ft;

   assign unused_ft = ^filter_type[DIM_W-1:1];
   assign state_dbg = state;

   // Out-of-range lengths fall back to a full-size edge.
   assign sz_eff   = (sz == '0 || 32'(sz) > MAX_EDGE) ? SZ_W'(MAX_EDGE) : sz;
   assign idx_last = (idx == len - SZ_W'(1));

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n   = state;
      cfg_ready = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      case (state)
         ST_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) state_n = ST_LOAD;
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid && idx_last) state_n = ST_FILTER;
         end
         ST_FILTER: begin
            out_valid = 1'b1;
            out_last  = idx_last;
            if (out_ready && idx_last) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // ---------------- strength selection ----------------
   intra_edge_strength_lut #(.DIM_W(DIM_W)) u_strength_lut (
      .w           (w_q),
      .h           (h_q),
      .filter_type (ft_q),
      .delta       (delta_q),
      .strength    (lut_strength)
   );

`ifdef INTRA_EDGE_STRENGTH_OVERRIDE_EN
   logic       ovr_en_q;
   logic [1:0] ovr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr_en_q <= 1'b0;
         ovr_q    <= 2'd0;
      end else if (state == ST_IDLE && cfg_valid) begin
         ovr_en_q <= strength_ovr_en;
         ovr_q    <= strength_ovr;
      end
   end

   assign sel_strength = ovr_en_q ? ovr_q : lut_strength;
`else
   assign sel_strength = lut_strength;
`endif

   // ---------------- control registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx      <= '0;
         len      <= '0;
         w_q      <= '0;
         h_q      <= '0;
         delta_q  <= '0;
         ft_q     <= 1'b0;
         strength <= 2'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cfg_valid) begin
                  w_q     <= w;
                  h_q     <= h;
                  delta_q <= delta;
                  ft_q    <= filter_type[0];
                  len     <= sz_eff;
                  idx     <= '0;
               end
            end
            ST_LOAD: begin
               strength <= sel_strength;
               if (in_valid) idx <= idx_last ? '0 : idx + SZ_W'(1);
            end
            ST_FILTER: begin
               if (out_ready) idx <= idx_last ? '0 : idx + SZ_W'(1);
            end
            default: idx <= '0;
         endcase
      end
   end

   // Sample buffer: contents are meaningless outside an edge, so no reset.
   always_ff @(posedge clk) begin
      if (state == ST_LOAD && in_valid) edge_buf[idx[IDX_W-1:0]] <= in_data;
   end

   // ---------------- kernel datapath ----------------
   // The buffer is never written during FILTER, so every tap reads the
   // original samples and out_data is naturally stable while stalled.
   always_comb begin
      acc = ACC_W'(8);
      pos = 0;
      for (int j = 0; j < KERNEL_TAPS; j++) begin
         pos = int'(idx) - 2 + j;
         if (pos < 0) pos = 0;
         if (pos > int'(len) - 1) pos = int'(len) - 1;
         acc = acc + ACC_W'(KERNEL[strength][j]) * ACC_W'(edge_buf[pos[IDX_W-1:0]]);
      end
      if (idx == '0 || len <= SZ_W'(2)) filt = edge_buf[idx[IDX_W-1:0]];
      else                              filt = acc[ACC_W-1:4];
   end

   assign out_data = (state == ST_FILTER) ? filt : '0;

endmodule

// File: tb/tb_intra_edge_filter.sv
// -----------------------------------------------------------------------------
// tb_intra_edge_filter
// Self-checking bench: drives config/edge transactions, predicts strength and
// filtered samples with a behavioural model, and compares each output beat.
// -----------------------------------------------------------------------------
module tb_intra_edge_filter;

   localparam int SW  = 10;
   localparam int ME  = 64;
   localparam int DW  = 10;
   localparam int SZW = $clog2(ME + 1);

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           cfg_valid = 1'b0;
   logic           cfg_ready;
   logic [DW-1:0]  w = '0, h = '0, filter_type = '0, delta = '0;
   logic [SZW-1:0] sz = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [SW-1:0]  in_data = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [SW-1:0]  out_data;
   logic           out_last;
   logic [1:0]     strength;
   logic [1:0]     state_dbg;
`ifdef INTRA_EDGE_STRENGTH_OVERRIDE_EN
   logic           strength_ovr_en = 1'b0;
   logic [1:0]     strength_ovr = 2'd0;
`endif

   int total = 0;
   int bad   = 0;

   logic [SW-1:0] exp_q[$];
   int edge_m [ME];
   int kern [3][5] = '{'{0, 4, 8, 4, 0}, '{0, 5, 6, 5, 0}, '{2, 4, 4, 4, 2}};
   int dims [5] = '{4, 8, 16, 32, 64};

   intra_edge_filter #(.SAMPLE_W(SW), .MAX_EDGE(ME), .DIM_W(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .w           (w),
      .h           (h),
      .filter_type (filter_type),
      .delta       (delta),
      .sz          (sz),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .strength    (strength),
      .state_dbg   (state_dbg)
`ifdef INTRA_EDGE_STRENGTH_OVERRIDE_EN
      ,
      .strength_ovr_en (strength_ovr_en),
      .strength_ovr    (strength_ovr)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int model_strength(int bw_w, int bw_h, int ft, int dl);
      int d = (dl < 0) ? -dl : dl;
      int b = bw_w + bw_h;
      int s = 0;
      if (ft == 0) begin
         if (b <= 8)       begin if (d >= 56) s = 1; end
         else if (b <= 12) begin if (d >= 40) s = 1; end
         else if (b <= 16) begin if (d >= 40) s = 1; end
         else if (b <= 24) begin if (d >= 8) s = 1; if (d >= 16) s = 2; if (d >= 32) s = 3; end
         else if (b <= 32) begin if (d >= 1) s = 1; if (d >= 4) s = 2; if (d >= 32) s = 3; end
         else              begin if (d >= 1) s = 3; end
      end else begin
         if (b <= 8)       begin if (d >= 40) s = 1; if (d >= 64) s = 2; end
         else if (b <= 16) begin if (d >= 20) s = 1; if (d >= 48) s = 2; end
         else if (b <= 24) begin if (d >= 4) s = 3; end
         else              begin if (d >= 1) s = 3; end
      end
      return s;
   endfunction

   function automatic int model_sample(int i, int s, int n);
      int sum = 8;
      int p;
      if (i == 0 || s == 0 || n <= 2) return edge_m[i];
      for (int j = 0; j < 5; j++) begin
         p = i - 2 + j;
         if (p < 0) p = 0;
         if (p > n - 1) p = n - 1;
         sum += kern[s-1][j] * edge_m[p];
      end
      return sum / 16;
   endfunction

   function automatic int eff_len(int s);
      return (s == 0 || s > ME) ? ME : s;
   endfunction

   task automatic load_model(input int n, input int s);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(SW'(model_sample(i, s, n)));
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) edge_m[i] = int'($urandom_range(0, (1 << SW) - 1));
   endtask

   // ---------------- drivers ----------------
   task automatic send_cfg(input int cw, input int ch, input int ft, input int dl,
                           input int s, input string tag);
      int cnt = 0;
      cfg_valid   = 1'b1;
      w           = DW'(cw);
      h           = DW'(ch);
      filter_type = DW'(ft);
      delta       = DW'(dl);
      sz          = SZW'(s);
      while (cfg_ready !== 1'b1 && cnt < 20) begin
         @(posedge clk); #1; cnt++;
      end
      total++;
      if (cfg_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s cfg_ready timeout got %b want 1", tag, cfg_ready);
      end
      @(posedge clk); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic send_edge(input int n, input int gaps, input int exp_s, input string tag);
      int cnt;
      for (int i = 0; i < n; i++) begin
         if (gaps != 0 && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = SW'(edge_m[i]);
         cnt = 0;
         while (in_ready !== 1'b1 && cnt < 20) begin
            @(posedge clk); #1; cnt++;
         end
         if (in_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL %s in_ready timeout at sample %0d", tag, i);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL %s first_out_valid got %b want 1", tag, out_valid);
      end
      total++;
      if (strength !== 2'(exp_s)) begin
         bad++;
         $display("FAIL %s strength got %0d want %0d", tag, strength, exp_s);
      end
   endtask

   // mode 0: always ready, 1: random ready, 2: ready every other cycle
   task automatic recv_edge(input int n, input int mode, input string tag);
      int k = 0;
      int cyc = 0;
      logic stalled = 1'b0;
      logic [SW-1:0] hd = '0;
      logic hl = 1'b0;
      logic [SW-1:0] exp;
      while (k < n && cyc < 4 * n + 40) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (cyc % 2 == 1);
         endcase
         total++;
         if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s out_valid at beat %0d got %b want 1", tag, k, out_valid);
         end
         if (stalled) begin
            total++;
            if (out_data !== hd || out_last !== hl) begin
               bad++;
               $display("FAIL %s stall_hold beat %0d got %0d/%b want %0d/%b",
                        tag, k, out_data, out_last, hd, hl);
            end
         end
         if (out_ready) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            total++;
            if (out_data !== exp) begin
               bad++;
               $display("FAIL %s data[%0d] got %0d want %0d", tag, k, out_data, exp);
            end
            total++;
            if (out_last !== (k == n - 1)) begin
               bad++;
               $display("FAIL %s last[%0d] got %b want %b", tag, k, out_last, (k == n - 1));
            end
            k++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            hd = out_data;
            hl = out_last;
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b0;
      total++;
      if (k != n) begin
         bad++;
         $display("FAIL %s beats got %0d want %0d", tag, k, n);
      end
      total++;
      if (out_valid !== 1'b0 || cfg_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s end_idle got valid=%b cfg_ready=%b want 0/1", tag, out_valid, cfg_ready);
      end
   endtask

   task automatic run_edge(input int cw, input int ch, input int ft, input int dl,
                           input int s, input int mode, input int gaps, input string tag);
      int n = eff_len(s);
      int st = model_strength(cw, ch, ft, dl);
      load_model(n, st);
      send_cfg(cw, ch, ft, dl, s, tag);
      send_edge(n, gaps, st, tag);
      recv_edge(n, mode, tag);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_last !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl got v=%b ir=%b l=%b want 0", out_valid, in_ready, out_last);
      end
      total++;
      if (out_data !== '0 || strength !== 2'd0 || state_dbg !== 2'd0) begin
         bad++;
         $display("FAIL reset_data got d=%0d s=%0d st=%0d want 0", out_data, strength, state_dbg);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (cfg_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release got cfg_ready=%b out_valid=%b want 1/0", cfg_ready, out_valid);
      end
   endtask

   task automatic test_strength_two();
      fill_random(4);
      run_edge(4, 4, 1, 65, 4, 0, 0, "str2");
      total++;
      if (strength !== 2'd2) begin
         bad++;
         $display("FAIL str2_hold got %0d want 2", strength);
      end
   endtask

   task automatic test_passthrough();
      logic [SW-1:0] raw[$];
      fill_random(8);
      for (int i = 0; i < 8; i++) raw.push_back(SW'(edge_m[i]));
      send_cfg(8, 8, 0, 0, 8, "pass");
      exp_q = raw;
      send_edge(8, 1, 0, "pass");
      recv_edge(8, 1, "pass");
   endtask

   task automatic test_ramp();
      edge_m[0] = 0; edge_m[1] = 16; edge_m[2] = 32; edge_m[3] = 48; edge_m[4] = 64;
      exp_q = '{10'd0, 10'd16, 10'd32, 10'd48, 10'd60};
      send_cfg(4, 4, 0, 60, 5, "ramp");
      send_edge(5, 0, 1, "ramp");
      recv_edge(5, 0, "ramp");
   endtask

   task automatic test_step();
      edge_m[0] = 0; edge_m[1] = 0; edge_m[2] = 160; edge_m[3] = 160; edge_m[4] = 160;
      exp_q = '{10'd0, 10'd60, 10'd100, 10'd140, 10'd160};
      send_cfg(32, 32, 0, -3, 5, "step");
      send_edge(5, 0, 3, "step");
      recv_edge(5, 0, "step");
   endtask

   task automatic test_small_sz();
      fill_random(2);
      run_edge(32, 32, 0, 9, 2, 1, 0, "sz2");
      fill_random(1);
      run_edge(32, 32, 1, -9, 1, 0, 0, "sz1");
   endtask

   task automatic test_stall();
      fill_random(ME);
      run_edge(16, 16, 1, 30, ME, 2, 0, "stall64");
   endtask

   task automatic test_random();
      int s;
      for (int it = 0; it < 12; it++) begin
         s = int'($urandom_range(1, ME));
         if (it == 0) s = 0;
         if (it == 1) s = 100;
         fill_random(eff_len(s));
         run_edge(dims[$urandom_range(0, 4)], dims[$urandom_range(0, 4)],
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 180)) - 90,
                  s, 1, 1, $sformatf("rnd%0d", it));
      end
   endtask

   task automatic test_reset_mid_filter();
      fill_random(16);
      load_model(16, 3);
      send_cfg(32, 32, 0, 7, 16, "rmid");
      send_edge(16, 0, 3, "rmid");
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (out_data !== exp_q[0]) begin
            bad++;
            $display("FAIL rmid_pre data[%0d] got %0d want %0d", i, out_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || strength !== 2'd0) begin
         bad++;
         $display("FAIL rmid_reset got v=%b l=%b d=%0d s=%0d want 0",
                  out_valid, out_last, out_data, strength);
      end
      @(posedge clk); #2;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rmid_quiet cycle %0d got %b want 0", i, out_valid);
         end
      end
      out_ready = 1'b0;
      exp_q.delete();
      fill_random(12);
      run_edge(8, 16, 1, 50, 12, 1, 1, "rmid_next");
   endtask

   // ---------------- sequence ----------------
   initial begin
      test_reset();
      test_strength_two();
      test_passthrough();
      test_ramp();
      test_step();
      test_small_sz();
      test_stall();
      test_random();
      test_reset_mid_filter();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/intra_edge_filter.md
INTRA_EDGE_FILTER -- requirements
Module: intra_edge_filter

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 10, edge sample bit depth (8/10/12).
REQ-002 SHALL have parameter MAX_EDGE, default 64, maximum edge samples buffered.
REQ-003 SHALL have parameter DIM_W, default 10, width of w, h, filter_type, delta.
REQ-004 SHALL have ports, with one clock and an asynchronous active-low reset:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid / cfg_ready  in / out  1  configuration handshake
- w, h  in  DIM_W  block width, height
- filter_type  in  DIM_W  bit 0 only is used
- delta  in  DIM_W signed  angle delta
- sz  in  clog2(MAX_EDGE+1)  edge length, 1..MAX_EDGE
- in_valid / in_ready  in / out  1  sample input handshake
- in_data  in  SAMPLE_W  unfiltered edge sample
- out_valid / out_ready  out / in  1  sample output handshake
- out_data  out  SAMPLE_W  filtered sample
- out_last  out  1  final sample of edge
- strength  out  2  selected strength, held from LOAD until the next cfg accept

Function
REQ-005 SHALL implement FSM IDLE -> LOAD -> FILTER -> IDLE.
REQ-006 IDLE: cfg_ready=1; on cfg_valid, SHALL latch w, h, filter_type, delta, sz and enter LOAD.
REQ-007 LOAD: in_ready=1; SHALL store in_data at index 0..sz-1 on each transfer and enter FILTER the cycle after transfer sz-1.
REQ-008 Strength SHALL be registered during LOAD per AV1 spec 7.11.2.9, with d=|delta| and blkWh=w+h.
REQ-009 FILTER: out_valid=1; SHALL emit one sample per out_ready cycle, index 0..sz-1, with out_last on sz-1, then return to IDLE.
REQ-010 out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-011 Output i SHALL equal (sum_j k[s][j]*edge[clamp(i-2+j,0,sz-1)] + 8) >> 4, using kernels k1=[0,4,8,4,0], k2=[0,5,6,5,0], k3=[2,4,4,4,2].
REQ-012 Index 0, strength 0, and sz<=2 SHALL pass the stored sample unchanged.
REQ-013 Accumulator SHALL be SAMPLE_W+4 bits with no overflow; the result fits SAMPLE_W without clamping.
REQ-014 Filtering SHALL read only original (unfiltered) buffer contents.
REQ-015 First out_valid SHALL occur exactly one cycle after the last in transfer.
REQ-016 sz=0 or sz>MAX_EDGE SHALL be treated as MAX_EDGE.

Reset
REQ-017 On rst_n low, SHALL asynchronously force IDLE; all outputs SHALL drop to 0 except cfg_ready, which becomes 1 after release; buffer contents are don't-care.
REQ-018 Reset mid-LOAD or mid-FILTER SHALL abandon the edge; no further out_valid SHALL occur until a new cfg transfer.

Configuration
REQ-019 With INTRA_EDGE_STRENGTH_OVERRIDE_EN defined, SHALL add inputs strength_ovr_en (1) and strength_ovr (2), sampled at cfg accept; when ovr_en=1, strength_ovr replaces the computed strength.
REQ-020 Without the macro, those ports SHALL be absent and strength SHALL always be computed.

Structure
REQ-021 Shared package intra_edge_pkg SHALL hold the state enum, kernel constant table, and blkWh/d threshold constants.
REQ-022 Strength selection SHALL be a combinational sub-module intra_edge_strength_lut; the kernel datapath stays in the top module.

Verification
REQ-023 w=4, h=4, type=1, delta=65 -> strength=2.
REQ-024 delta=0, sz=8, arbitrary samples -> strength=0; output equals input; out_last on the 8th sample.
REQ-025 Strength 1, sz=5, edge [0,16,32,48,64] -> out [0,16,32,48,60].
REQ-026 Strength 3, edge [0,0,160,160,160] -> out[1]=60, out[2]=100.
REQ-027 out_ready toggled every other cycle across a 64-sample edge -> no sample lost or duplicated; data stable while stalled.
REQ-028 rst_n pulsed low mid-FILTER -> out_valid=0 immediately; the next cfg/edge produces correct output.
